// File: rtl/rf_wr_arbiter.sv
// rtl/rf_wr_arbiter.sv - two-requester register-file write arbiter with alternating priority and handshake checking
module rf_wr_arbiter #(
  parameter int DATA_W = 16,
  parameter int SEL_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [SEL_W-1:0]  req0_sel,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [SEL_W-1:0]  req1_sel,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              wr_en,
  output logic [SEL_W-1:0]  wr_sel,
  output logic [DATA_W-1:0] wr_data,
  output logic              grant_id,
  output logic              err
);

  logic              prio;
  logic              stall0, stall1;
  logic [SEL_W-1:0]  stall_sel0, stall_sel1;
  logic [DATA_W-1:0] stall_data0, stall_data1;
  logic              viol0, viol1;
  logic              accept;

  // prio only matters when both requesters contend
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (rst) begin
      req0_ready = req0_valid && (!req1_valid || !prio);
      req1_ready = req1_valid && (!req0_valid || prio);
    end
  end

  assign accept = req0_ready || req1_ready;

  // A requester left waiting last cycle must present the identical request now
  always_comb begin
    viol0 = stall0 && (!req0_valid || (req0_sel != stall_sel0) || (req0_data != stall_data0));
    viol1 = stall1 && (!req1_valid || (req1_sel != stall_sel1) || (req1_data != stall_data1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en       <= 1'b0;
      wr_sel      <= '0;
      wr_data     <= '0;
      grant_id    <= 1'b0;
      err         <= 1'b0;
      prio        <= 1'b0;
      stall0      <= 1'b0;
      stall1      <= 1'b0;
      stall_sel0  <= '0;
      stall_sel1  <= '0;
      stall_data0 <= '0;
      stall_data1 <= '0;
    end else begin
      wr_en <= accept;
      if (accept) begin
        wr_sel   <= req1_ready ? req1_sel  : req0_sel;
        wr_data  <= req1_ready ? req1_data : req0_data;
        grant_id <= req1_ready;
        prio     <= req0_ready;
      end
      if (viol0 || viol1) begin
        err <= 1'b1;
      end
      stall0      <= req0_valid && !req0_ready;
      stall1      <= req1_valid && !req1_ready;
      stall_sel0  <= req0_sel;
      stall_sel1  <= req1_sel;
      stall_data0 <= req0_data;
      stall_data1 <= req1_data;
    end
  end

endmodule
